// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: ready/valid handshake with a 2-entry skid buffer and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready and out_valid are decoded from the state register only, so out_ready never
  // reaches in_ready combinationally.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid_in;

  assign in_ready  = (state != ST_SKID);
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      // Squash everything; a same-cycle input is dropped.
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next   = ST_MAIN;
            load_main_in = 1'b1;
          end
        end
        ST_MAIN: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_next   = ST_SKID;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_next     = ST_MAIN;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      // Data is left alone; zero control makes the bubble a NOP downstream.
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid_in) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (flush && (state != ST_EMPTY) && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic checked against a queue model.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state_dbg;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  // Reference model: the stage is a FIFO of capacity 2; when empty, the output
  // shows whatever the main register last held (control zeroed by reset/flush).
  ent_t          exp_q[$];
  logic [DW-1:0] idle_data;
  logic [CW-1:0] idle_ctrl;
  int            stall_exp, flush_exp;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  task automatic model_reset();
    exp_q.delete();
    idle_data = '0;
    idle_ctrl = '0;
    stall_exp = 0;
    flush_exp = 0;
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic cycle();
    logic exp_rdy, exp_vld, i_f, o_f;
    ent_t e;
    @(negedge clk);
    exp_rdy = (exp_q.size() < 2);
    exp_vld = (exp_q.size() > 0);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_vld);
    if (exp_vld) begin
      check("out_data", out_data, exp_q[0].d);
      check("out_ctrl", out_ctrl, exp_q[0].c);
    end else begin
      check("idle_data", out_data, idle_data);
      check("idle_ctrl", out_ctrl, idle_ctrl);
    end
`ifdef PIPE_STAGE_PERF_CNT_EN
    check("stall_cnt", stall_cnt, stall_exp);
    check("flush_cnt", flush_cnt, flush_exp);
`else
    check("stall_cnt", stall_cnt, 0);
    check("flush_cnt", flush_cnt, 0);
`endif
    i_f = in_valid && exp_rdy;
    o_f = out_ready && exp_vld;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (exp_vld && !out_ready && stall_exp < CNT_MAX) stall_exp++;
      if (flush && exp_vld && flush_exp < CNT_MAX) flush_exp++;
      if (flush) begin
        if (exp_q.size() > 0) idle_data = exp_q[0].d;
        idle_ctrl = '0;
        exp_q.delete();
      end else begin
        if (o_f) begin
          e = exp_q.pop_front();
          idle_data = e.d;
          idle_ctrl = e.c;
        end
        if (i_f) begin
          e.d = in_data;
          e.c = in_ctrl;
          exp_q.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Streaming with out_ready high
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), CW'($urandom), 1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();

    // Back-pressure: A, B stalled, then released
    drive(1'b1, 32'hA, 16'h0A0A, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hB, 16'h0B0B, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hC, 16'h0C0C, 1'b0, 1'b0, 1'b0); repeat (2) cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); repeat (3) cycle();

    // Flush while SKID holds two entries with all-ones control; input dropped
    drive(1'b1, 32'h11, 16'hFFFF, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h22, 16'hFFFF, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h33, 16'h1234, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); repeat (2) cycle();

    // Reset and flush together, then flush while empty
    drive(1'b1, 32'h44, 16'h5555, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h55, 16'h6666, 1'b0, 1'b1, 1'b1); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); cycle();

    // Counter saturation: hold one entry stalled for 20 cycles
    drive(1'b1, 32'h66, 16'h7777, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0); repeat (2) cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 299) == 0));
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
